run_dump_ctrl: RTL and testbench

Run-control and state-dump sequencer for the single-cycle processor. It gates processor execution through an enable, and stops on a halt word, a branch-to-self, or a cycle budget. It then walks the register file and data memory through their read ports and streams each word out on a valid/ready port. It is the synthesizable, parametrised successor to the fixed-delay load/run/dump harness: it provides run-until-halt plus an ordered dump in place of a hard-coded cycle count.

---
 rtl/run_dump_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_run_dump_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: run-control and state-dump sequencer for the single-cycle
// processor. Gates processor execution via cpu_en until a halt word, a
// branch-to-self or the cycle budget stops it. It then streams the register
// file followed by the data memory out on a valid/ready port.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        single-cycle pulse starting a run (honoured in IDLE/DONE)
//   max_cycles   execution budget, 0 = unlimited
//   pc, instr    current processor PC and the instruction at that PC
//   cpu_en       processor state-update enable
//   dump_sel     0 = register file, 1 = data memory
//   dump_addr    word index driven to the selected read port
//   dump_data    combinational read data for dump_addr
//   dump_valid   dump_word is valid
//   dump_ready   consumer accepts dump_word
//   dump_word    dump_data passed through to the consumer
//   busy         RUN, DUMP_REG or DUMP_MEM
//   done         DONE
//   halt_cause   00 none, 01 halt word, 10 self-loop, 11 budget
//   cycle_count  number of enabled cycles in the current run
module run_dump_ctrl #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          CYCLE_W    = 16,
  parameter int          IDX_W      = 10,
  parameter int          REG_DEPTH  = 32,
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CYCLE_W-1:0] max_cycles,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [DATA_W-1:0]  instr,
  output logic               cpu_en,
  output logic               dump_sel,
  output logic [IDX_W-1:0]   dump_addr,
  input  logic [DATA_W-1:0]  dump_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DATA_W-1:0]  dump_word,
  output logic               busy,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [CYCLE_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_DUMP_REG = 3'd2,
    S_DUMP_MEM = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0]   REG_LAST  = IDX_W'(REG_DEPTH - 1);
  localparam logic [IDX_W-1:0]   MEM_LAST  = IDX_W'(DMEM_DEPTH - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [CYCLE_W-1:0] CYC_ONE   = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] CYC_MAX   = {CYCLE_W{1'b1}};
  localparam logic [DATA_W-1:0]  HALT_INSN = DATA_W'(HALT_WORD);

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [1:0]         cause_q, cause_d;
  logic [ADDR_W-1:0]  pc_prev_q, pc_prev_d;
  logic               pc_prev_valid_q, pc_prev_valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [1:0]         halt_cause_s;
  logic               cpu_en_s;
  logic               dump_valid_s;
  logic               dump_sel_s;

  // Saturating cycle counter increment; stops at all-ones.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    if (v == CYC_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CYC_ONE;
    end
  endfunction

  // Halt detection in priority order: halt word, branch-to-self, budget.
  always_comb begin
    halt_cause_s = 2'b00;
    if (instr == HALT_INSN) begin
      halt_cause_s = 2'b01;
    end else if (pc_prev_valid_q && (pc == pc_prev_q)) begin
      halt_cause_s = 2'b10;
    end else if ((max_cycles != '0) && (cycle_q == max_cycles)) begin
      halt_cause_s = 2'b11;
    end else begin
      halt_cause_s = 2'b00;
    end
  end

  // Next-state and output decode for the sequencer.
  always_comb begin
    state_d         = state_q;
    cycle_d         = cycle_q;
    cause_d         = cause_q;
    pc_prev_d       = pc_prev_q;
    pc_prev_valid_d = pc_prev_valid_q;
    idx_d           = idx_q;
    cpu_en_s        = 1'b0;
    dump_valid_s    = 1'b0;
    dump_sel_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cycle_d         = '0;
        cause_d         = 2'b00;
        pc_prev_valid_d = 1'b0;
        idx_d           = '0;
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (halt_cause_s != 2'b00) begin
          // Processor is frozen this cycle, so the halting instruction
          // never commits and the snapshot starts from a stable state.
          cause_d = halt_cause_s;
          idx_d   = '0;
          state_d = S_DUMP_REG;
        end else begin
          cpu_en_s        = 1'b1;
          cycle_d         = sat_inc(cycle_q);
          pc_prev_d       = pc;
          pc_prev_valid_d = 1'b1;
        end
      end

      S_DUMP_REG: begin
        dump_valid_s = 1'b1;
        dump_sel_s   = 1'b0;
        if (dump_ready) begin
          if (idx_q == REG_LAST) begin
            idx_d   = '0;
            state_d = S_DUMP_MEM;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      S_DUMP_MEM: begin
        dump_valid_s = 1'b1;
        dump_sel_s   = 1'b1;
        if (dump_ready) begin
          if (idx_q == MEM_LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      S_DONE: begin
        if (start) begin
          cycle_d         = '0;
          cause_d         = 2'b00;
          pc_prev_valid_d = 1'b0;
          idx_d           = '0;
          state_d         = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d         = S_IDLE;
        cycle_d         = '0;
        cause_d         = 2'b00;
        pc_prev_valid_d = 1'b0;
        idx_d           = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cycle_q         <= '0;
      cause_q         <= 2'b00;
      pc_prev_q       <= '0;
      pc_prev_valid_q <= 1'b0;
      idx_q           <= '0;
    end else begin
      state_q         <= state_d;
      cycle_q         <= cycle_d;
      cause_q         <= cause_d;
      pc_prev_q       <= pc_prev_d;
      pc_prev_valid_q <= pc_prev_valid_d;
      idx_q           <= idx_d;
    end
  end

  // idx_q is zero outside the dump states, so it can drive the port directly.
  assign cpu_en      = cpu_en_s;
  assign dump_valid  = dump_valid_s;
  assign dump_sel    = dump_sel_s;
  assign dump_addr   = dump_valid_s ? idx_q : '0;
  assign dump_word   = dump_data;
  assign busy        = (state_q == S_RUN) || (state_q == S_DUMP_REG) ||
                       (state_q == S_DUMP_MEM);
  assign done        = (state_q == S_DONE);
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Self-checking bench for run_dump_ctrl. A toy processor (straight-line PC
// advance, branch-to-self opcode) and read-only register/memory arrays are
// modelled here; an instruction-level reference walk predicts each run.
module tb_run_dump_ctrl;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam int NREG = 32;
  localparam int NMEM = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] max_cycles = 16'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] instr;
  logic        cpu_en;
  logic        dump_sel;
  logic [9:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [31:0] dump_word;
  logic        busy;
  logic        done;
  logic [1:0]  halt_cause;
  logic [15:0] cycle_count;

  logic        cpu_rst = 1'b0;
  logic [31:0] imem    [0:255];
  logic [31:0] tb_regs [0:NREG-1];
  logic [31:0] tb_dmem [0:NMEM-1];

  int n_cmp = 0;
  int n_fail = 0;

  // Observations of the last run.
  int          obs_en, first_valid, done_cyc;
  bit          timed_out;
  logic [1:0]  obs_cause, c1_cause;
  logic [15:0] obs_cnt, c1_cnt;
  logic [31:0] obs_pc;
  logic        got_sel  [$];
  logic [9:0]  got_addr [$];
  logic [31:0] got_word [$];
  logic [31:0] diff_got, diff_exp;

  run_dump_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .max_cycles(max_cycles),
    .pc(pc), .instr(instr), .cpu_en(cpu_en), .dump_sel(dump_sel),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_word(dump_word), .busy(busy), .done(done),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  assign instr     = imem[pc[9:2]];
  assign dump_data = dump_sel ? tb_dmem[dump_addr[5:0]] : tb_regs[dump_addr[4:0]];

  // Toy processor: advance by one word unless the instruction branches to itself.
  always @(posedge clock) begin
    if (cpu_rst) pc <= 32'd0;
    else if (cpu_en) pc <= (instr == BEQ) ? pc : pc + 32'd4;
  end

  // Reference: step the program instruction by instruction from pc 0.
  function automatic void model_run(input logic [15:0] maxc, output int en,
                                    output logic [1:0] cause, output logic [31:0] hpc);
    logic [31:0] p, prev, w;
    bit pv;
    p = 32'd0; prev = 32'd0; pv = 0; en = 0; cause = 2'b00; hpc = 32'd0;
    for (int g = 0; g < 70000; g++) begin
      w = imem[p[9:2]];
      if (w == HALT) cause = 2'b01;
      else if (pv && p == prev) cause = 2'b10;
      else if (maxc != 16'd0 && en == int'(maxc)) cause = 2'b11;
      if (cause != 2'b00) begin
        hpc = p;
        return;
      end
      prev = p; pv = 1;
      p = (w == BEQ) ? p : p + 32'd4;
      en++;
    end
  endfunction

  // Index of the first dump entry that departs from "all regs then all dmem", -1 if none.
  function automatic int dump_diff();
    logic        es;
    logic [9:0]  ea;
    logic [31:0] ew;
    if (got_word.size() != NREG + NMEM) begin
      diff_got = got_word.size(); diff_exp = NREG + NMEM;
      return -2;
    end
    for (int i = 0; i < NREG + NMEM; i++) begin
      es = (i >= NREG);
      ea = es ? 10'(i - NREG) : 10'(i);
      ew = es ? tb_dmem[i - NREG] : tb_regs[i];
      if (got_sel[i] !== es || got_addr[i] !== ea || got_word[i] !== ew) begin
        diff_got = {got_sel[i], got_addr[i][4:0], got_word[i][25:0]};
        diff_exp = {es, ea[4:0], ew[25:0]};
        return i;
      end
    end
    return -1;
  endfunction

  task automatic gen_prog(input int halt_at, input int loop_at);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT || w == BEQ) w = 32'h0000_0013;
      imem[i] = w;
    end
    if (loop_at >= 0) imem[loop_at] = BEQ;
    if (halt_at >= 0) imem[halt_at] = HALT;
  endtask

  task automatic fill_regs(input bit ramp);
    for (int i = 0; i < NREG; i++) tb_regs[i] = ramp ? 32'(i) : $urandom;
    for (int i = 0; i < NMEM; i++) tb_dmem[i] = ramp ? 32'h100 + 32'(i) : $urandom;
  endtask

  // Drive one start pulse and record the run and dump until done (bounded).
  task automatic run_once(input logic [15:0] maxc, input int ready_pct, input bit noise);
    got_sel.delete(); got_addr.delete(); got_word.delete();
    timed_out = 0; obs_en = 0; first_valid = -1; done_cyc = -1;
    max_cycles = maxc;
    @(negedge clock); cpu_rst = 1'b1;
    @(negedge clock); cpu_rst = 1'b0; start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clock);
      if (c == 1) begin c1_cnt = cycle_count; c1_cause = halt_cause; end
      if (done) begin done_cyc = c; break; end
      if (cpu_en) obs_en++;
      if (dump_valid && first_valid < 0) first_valid = c;
      dump_ready = ($urandom_range(99) < ready_pct);
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      #1;
      if (dump_valid && dump_ready) begin
        got_sel.push_back(dump_sel); got_addr.push_back(dump_addr);
        got_word.push_back(dump_word);
      end
    end
    start = 1'b0;
    if (done_cyc < 0) timed_out = 1;
    obs_cause = halt_cause; obs_cnt = cycle_count; obs_pc = pc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
    n_cmp++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid got=%b exp=0", dump_valid); end
    n_cmp++; if (dump_sel !== 1'b0) begin n_fail++; $display("FAIL reset_dump_sel got=%b exp=0", dump_sel); end
    n_cmp++; if (dump_addr !== 10'd0) begin n_fail++; $display("FAIL reset_dump_addr got=%0d exp=0", dump_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (halt_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got=%b exp=00", halt_cause); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_budget();
    int en; logic [1:0] ca; logic [31:0] hp; int d;
    gen_prog(-1, -1); fill_regs(0);
    model_run(16'd18, en, ca, hp);
    run_once(16'd18, 100, 0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL budget_timeout got=no_done exp=done"); end
    n_cmp++; if (obs_en !== 18 || en != 18) begin n_fail++; $display("FAIL budget_en got=%0d exp=18", obs_en); end
    n_cmp++; if (obs_cause !== 2'b11) begin n_fail++; $display("FAIL budget_cause got=%b exp=11", obs_cause); end
    n_cmp++; if (obs_cnt !== 16'd18) begin n_fail++; $display("FAIL budget_count got=%0d exp=18", obs_cnt); end
    n_cmp++; if (first_valid !== en + 2) begin n_fail++; $display("FAIL budget_first_valid got=%0d exp=%0d", first_valid, en + 2); end
    n_cmp++; if (done_cyc !== en + 2 + NREG + NMEM) begin n_fail++; $display("FAIL budget_done_cycle got=%0d exp=%0d", done_cyc, en + 2 + NREG + NMEM); end
    d = dump_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL budget_dump idx=%0d got=%h exp=%h", d, diff_got, diff_exp); end
  endtask

  task automatic test_halt_word();
    gen_prog(4, -1); fill_regs(0);
    run_once(16'd0, 100, 0);
    n_cmp++; if (obs_en !== 4) begin n_fail++; $display("FAIL halt_en got=%0d exp=4", obs_en); end
    n_cmp++; if (obs_cause !== 2'b01) begin n_fail++; $display("FAIL halt_cause got=%b exp=01", obs_cause); end
    n_cmp++; if (obs_pc !== 32'd16) begin n_fail++; $display("FAIL halt_pc got=%0d exp=16", obs_pc); end
  endtask

  task automatic test_self_loop();
    gen_prog(-1, 2); fill_regs(0);
    run_once(16'd0, 100, 0);
    n_cmp++; if (obs_en !== 3) begin n_fail++; $display("FAIL loop_en got=%0d exp=3", obs_en); end
    n_cmp++; if (obs_cause !== 2'b10) begin n_fail++; $display("FAIL loop_cause got=%b exp=10", obs_cause); end
    n_cmp++; if (first_valid !== 5) begin n_fail++; $display("FAIL loop_first_valid got=%0d exp=5", first_valid); end
  endtask

  task automatic test_dump_backpressure();
    int d;
    gen_prog(-1, -1); fill_regs(1);
    run_once(16'd5, 40, 1);
    d = dump_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL bp_dump idx=%0d got=%h exp=%h", d, diff_got, diff_exp); end
    n_cmp++; if (done !== 1'b1 || timed_out) begin n_fail++; $display("FAIL bp_done got=%b exp=1", done); end
    n_cmp++; if (obs_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", obs_cnt); end
  endtask

  task automatic test_reset_mid_dump();
    bit hit; int d;
    gen_prog(3, -1); fill_regs(1);
    hit = 0; max_cycles = 16'd0;
    @(negedge clock); cpu_rst = 1'b1;
    @(negedge clock); cpu_rst = 1'b0; start = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      start = 1'b0; dump_ready = 1'b1;
      if (dump_valid && !dump_sel && dump_addr == 10'd10) begin hit = 1; break; end
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL midreset_reach got=no_index10 exp=index10"); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_en, dump_valid, dump_sel, dump_addr, busy, done, halt_cause, cycle_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {cpu_en, dump_valid, dump_sel, dump_addr, busy, done, halt_cause, cycle_count});
    end
    @(negedge clock); reset_n = 1'b1;
    run_once(16'd0, 70, 0);
    d = dump_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL midreset_dump idx=%0d got=%h exp=%h", d, diff_got, diff_exp); end
    n_cmp++; if (obs_en !== 3 || obs_cause !== 2'b01) begin n_fail++; $display("FAIL midreset_run got=%0d/%b exp=3/01", obs_en, obs_cause); end
  endtask

  task automatic test_restart();
    int en1; logic [1:0] ca1; logic [15:0] cn1;
    gen_prog(-1, 9); fill_regs(0);
    run_once(16'd7, 100, 0);
    en1 = obs_en; ca1 = obs_cause; cn1 = obs_cnt;
    n_cmp++; if (ca1 !== 2'b11 || cn1 !== 16'd7) begin n_fail++; $display("FAIL restart_first got=%b/%0d exp=11/7", ca1, cn1); end
    run_once(16'd7, 100, 0);
    n_cmp++; if (c1_cnt !== 16'd0 || c1_cause !== 2'b00) begin n_fail++; $display("FAIL restart_clear got=%0d/%b exp=0/00", c1_cnt, c1_cause); end
    n_cmp++; if (obs_en !== en1 || obs_cause !== ca1 || obs_cnt !== cn1) begin
      n_fail++; $display("FAIL restart_repeat got=%0d/%b/%0d exp=%0d/%b/%0d", obs_en, obs_cause, obs_cnt, en1, ca1, cn1);
    end
  endtask

  task automatic test_random();
    int en; logic [1:0] ca; logic [31:0] hp; logic [15:0] mc; int d;
    for (int it = 0; it < 8; it++) begin
      gen_prog($urandom_range(60), $urandom_range(60)); fill_regs(0);
      mc = 16'($urandom_range(70));
      model_run(mc, en, ca, hp);
      run_once(mc, 60, 1);
      n_cmp++;
      if (timed_out || obs_en !== en || obs_cause !== ca || obs_cnt !== 16'(en) || obs_pc !== hp) begin
        n_fail++;
        $display("FAIL random_run it=%0d got=%0d/%b/%0d/%0d exp=%0d/%b/%0d/%0d",
                 it, obs_en, obs_cause, obs_cnt, obs_pc, en, ca, en, hp);
      end
      n_cmp++; if (first_valid !== en + 2) begin n_fail++; $display("FAIL random_first_valid it=%0d got=%0d exp=%0d", it, first_valid, en + 2); end
      d = dump_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL random_dump it=%0d idx=%0d got=%h exp=%h", it, d, diff_got, diff_exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    fill_regs(1);
    test_reset();
    test_budget();
    test_halt_word();
    test_self_loop();
    test_dump_backpressure();
    test_reset_mid_dump();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
